// File: rtl/pRISC_pkg.sv
// Shared pRISC definitions: opcode constants and the fetch-sequencer state encoding.
package pRISC_pkg;

    localparam logic [5:0] OP_BR   = 6'b101011;
    localparam logic [5:0] OP_CALL = 6'b101000;
    localparam logic [5:0] OP_BREG = 6'b100000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StHalt  = 2'd3
    } state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for a retiring instruction: sequential, PC-relative or register-indirect.
module pc_next_calc
    import pRISC_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OFF_W  = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [5:0]        opcode,
    input  logic              br_taken,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [ADDR_W-1:0] br_reg,
    output logic [ADDR_W-1:0] next_pc,
    output logic              is_call
);

    logic [ADDR_W-1:0] pc_inc;

    always_comb begin
        pc_inc  = pc + ADDR_W'(1);
        next_pc = pc_inc;
        // br_taken decides; opcode only chooses the target mode. HALT always steps by one.
        if (br_taken && (opcode != OP_HALT)) begin
            if (opcode == OP_BREG) begin
                next_pc = br_reg;
            end else begin
                next_pc = pc_inc + ADDR_W'($signed(br_off));
            end
        end
        is_call = br_taken && (opcode == OP_CALL);
    end

endmodule

// File: rtl/pc_sequencer.sv
// pRISC program counter and fetch sequencer: fetch handshake, instruction latch,
// next-PC update on retirement, call link generation and retired-instruction count.
module pc_sequencer
    import pRISC_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       OFF_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ack,
    input  logic [31:0]       instr_in,
    input  logic              exec_done,
    input  logic [5:0]        opcode,
    input  logic              br_taken,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [ADDR_W-1:0] br_reg,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_req,
    output logic [31:0]       instr,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_addr,
    output logic              halted,
    output logic [31:0]       instret
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              link_we_q;
    logic [ADDR_W-1:0] link_addr_q;
    logic [31:0]       instret_q;
    logic              fetch_req_q;
    logic              halted_q;

    logic [ADDR_W-1:0] next_pc;
    logic              is_call;

    pc_next_calc #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_next_calc (
        .pc       (pc_q),
        .opcode   (opcode),
        .br_taken (br_taken),
        .br_off   (br_off),
        .br_reg   (br_reg),
        .next_pc  (next_pc),
        .is_call  (is_call)
    );

    // fetch_req/halted are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            link_we_q   <= 1'b0;
            link_addr_q <= '0;
            instret_q   <= '0;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            link_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    state_q     <= StFetch;
                    fetch_req_q <= 1'b1;
                end
                StFetch: begin
                    if (fetch_ack) begin
                        instr_q     <= instr_in;
                        state_q     <= StExec;
                        fetch_req_q <= 1'b0;
                    end
                end
                StExec: begin
                    if (exec_done) begin
                        instret_q <= instret_q + 32'd1;
                        pc_q      <= next_pc;
                        if (is_call) begin
                            link_we_q   <= 1'b1;
                            link_addr_q <= pc_q + ADDR_W'(1);
                        end
                        if (opcode == OP_HALT) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else begin
                            state_q     <= StFetch;
                            fetch_req_q <= 1'b1;
                        end
                    end
                end
                StHalt: begin
                end
                default: begin
                    state_q     <= StIdle;
                    fetch_req_q <= 1'b0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign fetch_req = fetch_req_q;
    assign instr     = instr_q;
    assign link_we   = link_we_q;
    assign link_addr = link_addr_q;
    assign halted    = halted_q;
    assign instret   = instret_q;

endmodule
